// File: rtl/cpu_bridge_pkg.sv
// Shared types and helpers for the CPU-to-pin-bus bridge.
// Holds the transaction state encoding and the beat-count arithmetic.
package cpu_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WDATA,
      ST_TURN,
      ST_RDATA,
      ST_DONE
   } state_e;

   // Number of PIN_W-wide beats needed to carry a WIDTH-bit field.
   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/beat_counter.sv
// Small loadable up-counter with a terminal-value flag.
// Serves as both the beat index and the read-ack timeout counter.
module beat_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             inc_i,
   input  logic [WIDTH-1:0] term_val_i,
   output logic [WIDTH-1:0] count_o,
   output logic             term_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (inc_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples its inputs from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign term_o  = (count_q == term_val_i);

endmodule

// File: rtl/cpu_pin_bridge.sv
// Serialises a parallel CPU read/write request onto a narrow pin bus:
// address beats, then write-data beats or a turnaround and ack-gated read beats.
module cpu_pin_bridge
   import cpu_bridge_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int PIN_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [PIN_W-1:0]  pin_out,
   input  logic [PIN_W-1:0]  pin_in,
   output logic              pin_oe,
   output logic              pin_start,
   output logic              pin_we,
   input  logic              pin_ack
);

   localparam int ABEATS = ceil_div(ADDR_W, PIN_W);
   localparam int DBEATS = ceil_div(DATA_W, PIN_W);
   localparam int MAXB   = (ABEATS > DBEATS) ? ABEATS : DBEATS;
   localparam int BEAT_W = $clog2(MAXB + 1);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int AP_W   = ABEATS * PIN_W;
   localparam int DP_W   = DBEATS * PIN_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              we_q, we_d;
   logic              err_q, err_d;

   logic [BEAT_W-1:0] beat_cnt;
   logic [BEAT_W-1:0] beat_term_val;
   logic              beat_term, beat_load, beat_inc;
   logic              wait_term, wait_load, wait_inc;
   logic [WAIT_W-1:0] wait_cnt_unused;
   int                beat_idx;

   logic [AP_W-1:0]   addr_pad;
   logic [DP_W-1:0]   wdata_pad;

   // Zero-extend so a partial last beat carries zeros above the field width.
   assign addr_pad  = AP_W'(addr_q);
   assign wdata_pad = DP_W'(wdata_q);
   assign beat_idx  = int'(beat_cnt);

   // Both counters restart on every state change; the wait count also restarts per ack.
   assign beat_load = (state_d != state_q);
   assign wait_load = (state_d != state_q) || ((state_q == ST_RDATA) && pin_ack);

   beat_counter #(.WIDTH(BEAT_W)) u_beat_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (beat_load),
      .load_val_i ('0),
      .inc_i      (beat_inc),
      .term_val_i (beat_term_val),
      .count_o    (beat_cnt),
      .term_o     (beat_term)
   );

   beat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (wait_load),
      .load_val_i ('0),
      .inc_i      (wait_inc),
      .term_val_i (WAIT_W'(TIMEOUT - 1)),
      .count_o    (wait_cnt_unused),
      .term_o     (wait_term)
   );

   // NOTE: every output and next-state variable gets a default before the case
   // so no path leaves a value unassigned, which would infer a latch.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      we_d          = we_q;
      err_d         = err_q;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      rsp_rdata     = '0;
      rsp_err       = 1'b0;
      pin_out       = '0;
      pin_oe        = 1'b0;
      pin_start     = 1'b0;
      pin_we        = 1'b0;
      beat_inc      = 1'b0;
      wait_inc      = 1'b0;
      beat_term_val = (state_q == ST_ADDR) ? BEAT_W'(ABEATS - 1) : BEAT_W'(DBEATS - 1);

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = ST_ADDR;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               we_d    = req_we;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_ADDR: begin
            pin_oe    = 1'b1;
            pin_we    = we_q;
            pin_start = (beat_cnt == '0);
            pin_out   = addr_pad[beat_idx*PIN_W +: PIN_W];
            beat_inc  = 1'b1;
            if (beat_term) begin
               state_d = we_q ? ST_WDATA : ST_TURN;
            end
         end
         ST_WDATA: begin
            pin_oe   = 1'b1;
            pin_we   = we_q;
            pin_out  = wdata_pad[beat_idx*PIN_W +: PIN_W];
            beat_inc = 1'b1;
            if (beat_term) begin
               state_d = ST_DONE;
            end
         end
         ST_TURN: begin
            pin_we  = we_q;
            state_d = ST_RDATA;
         end
         ST_RDATA: begin
            pin_we = we_q;
            if (pin_ack) begin
               beat_inc = 1'b1;
               // Bits of the final beat beyond DATA_W simply have no destination.
               for (int b = 0; b < DATA_W; b++) begin
                  if (b / PIN_W == beat_idx) begin
                     rdata_d[b] = pin_in[b % PIN_W];
                  end
               end
               if (beat_term) begin
                  state_d = ST_DONE;
               end
            end else if (wait_term) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               wait_inc = 1'b1;
            end
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = we_q ? '0 : rdata_q;
            pin_we    = we_q;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_cpu_pin_bridge.sv
// Self-checking bench for cpu_pin_bridge: vector table of transactions with a
// response scoreboard, plus hand sequences for reset, back-to-back and odd widths.
module tb_cpu_pin_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [7:0]  pin_out, pin_in;
   logic        pin_oe, pin_start, pin_we, pin_ack;

   logic        req_valid2, req_ready2, req_we2;
   logic [11:0] req_addr2;
   logic [19:0] req_wdata2;
   logic        rsp_valid2, rsp_err2;
   logic [19:0] rsp_rdata2;
   logic [7:0]  pin_out2, pin_in2;
   logic        pin_oe2, pin_start2, pin_we2, pin_ack2;

   always #5 clk = ~clk;

   cpu_pin_bridge dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .pin_out   (pin_out),
      .pin_in    (pin_in),
      .pin_oe    (pin_oe),
      .pin_start (pin_start),
      .pin_we    (pin_we),
      .pin_ack   (pin_ack)
   );

   cpu_pin_bridge #(.ADDR_W(12), .DATA_W(20), .PIN_W(8), .TIMEOUT(16)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid2),
      .req_ready (req_ready2),
      .req_we    (req_we2),
      .req_addr  (req_addr2),
      .req_wdata (req_wdata2),
      .rsp_valid (rsp_valid2),
      .rsp_rdata (rsp_rdata2),
      .rsp_err   (rsp_err2),
      .pin_out   (pin_out2),
      .pin_in    (pin_in2),
      .pin_oe    (pin_oe2),
      .pin_start (pin_start2),
      .pin_we    (pin_we2),
      .pin_ack   (pin_ack2)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          gap;
      int          nack;
      logic [31:0] rbeats;
      logic [63:0] exp_beats;
      int          exp_nb;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic [63:0] beats;
      int          nb;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[5];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Starts just after a rising edge; returns just after the edge following DONE.
   task automatic run_txn(input vec_t v);
      exp_t        e;
      logic [63:0] got = '0;
      int          nb = 0;
      int          k = 0;
      bit          done = 1'b0;
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      e.lat   = v.exp_lat;
      e.beats = v.exp_beats;
      e.nb    = v.exp_nb;
      sb.push_back(e);
      req_valid = 1'b1;
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         if (cyc > 1) begin
            req_valid = 1'b0;
            req_addr  = ~v.addr;
            req_wdata = ~v.wdata;
         end
         pin_ack = 1'b0;
         pin_in  = 8'h00;
         if (!v.we) begin
            if (cyc < 7) begin
               pin_ack = 1'b1;
               pin_in  = 8'h5A;
            end else if (k < v.nack && (cyc - 7) % (v.gap + 1) == 0) begin
               pin_ack = 1'b1;
               pin_in  = v.rbeats[k*8 +: 8];
               k++;
            end
         end
         @(negedge clk);
         if (cyc == 1) check("accept_ready", req_ready, 1'b1);
         if (!v.we && cyc == 6) begin
            check("turn_oe", pin_oe, 1'b0);
            check("turn_out", pin_out, 8'h00);
         end
         if (pin_oe) begin
            check("pin_start", pin_start, (nb == 0));
            check("pin_we", pin_we, v.we);
            if (nb < 8) got[nb*8 +: 8] = pin_out;
            nb++;
         end
         if (rsp_valid) begin
            e = sb.pop_front();
            check("rsp_latency", cyc, e.lat);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", rsp_err, e.err);
            check("beat_values", got, e.beats);
            check("beat_count", nb, e.nb);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         check("rsp_timeout", 1'b0, 1'b1);
         void'(sb.pop_front());
      end
      pin_ack = 1'b0;
      pin_in  = 8'h00;
   endtask

   initial begin
      int r1, r2, pulses, nb2, lat2;
      logic [39:0] got2;

      vecs[0] = '{1'b1, 32'h12345678, 32'hCAFEBABE, 0, 0, 32'h0,
                  64'hCAFEBABE_12345678, 8, 32'h0, 1'b0, 10};
      vecs[1] = '{1'b0, 32'h00000010, 32'h0, 0, 4, 32'hDEADBEEF,
                  64'h00000000_00000010, 4, 32'hDEADBEEF, 1'b0, 11};
      vecs[2] = '{1'b0, 32'h00000010, 32'h0, 3, 4, 32'hDEADBEEF,
                  64'h00000000_00000010, 4, 32'hDEADBEEF, 1'b0, 20};
      vecs[3] = '{1'b0, 32'h55AA0001, 32'h0, 0, 2, 32'h0000BBAA,
                  64'h00000000_55AA0001, 4, 32'h0000BBAA, 1'b1, 25};
      vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h0,
                  64'h00000001_FFFFFFFF, 8, 32'h0, 1'b0, 10};

      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      pin_in = '0; pin_ack = 1'b0;
      req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
      pin_in2 = '0; pin_ack2 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_pin_out", pin_out, 8'h00);
      check("rst_pin_oe", pin_oe, 1'b0);
      check("rst_pin_start", pin_start, 1'b0);
      check("rst_pin_we", pin_we, 1'b0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) run_txn(vecs[i]);

      // Request held high: second accept lands the cycle after DONE.
      r1 = 0; r2 = 0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h12345678; req_wdata = 32'hCAFEBABE;
      for (int c = 1; c <= 40 && r2 == 0; c++) begin
         @(negedge clk);
         if (c == 10) check("b2b_ready_in_done", req_ready, 1'b0);
         if (c == 11) check("b2b_ready_after_done", req_ready, 1'b1);
         if (rsp_valid) begin
            if (r1 == 0) r1 = c;
            else r2 = c;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      check("b2b_first_rsp", r1, 10);
      check("b2b_second_rsp", r2, 20);

      // Reset in the middle of the write-data phase aborts silently.
      pulses = 0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0BADF00D; req_wdata = 32'h11223344;
      for (int c = 1; c <= 7; c++) begin
         if (c == 2) req_valid = 1'b0;
         if (c == 7) rst = 1'b1;
         @(negedge clk);
         if (c == 7) check("rst_mid_wdata_oe", pin_oe, 1'b1);
         if (rsp_valid) pulses++;
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("post_rst_oe", pin_oe, 1'b0);
            check("post_rst_ready", req_ready, 1'b1);
            check("post_rst_out", pin_out, 8'h00);
         end
         if (rsp_valid) pulses++;
         @(posedge clk);
         #1;
      end
      check("abort_no_rsp", pulses, 0);
      run_txn(vecs[0]);

      // Odd widths: 12-bit address and 20-bit data on an 8-bit bus.
      got2 = '0; nb2 = 0; lat2 = 0;
      req_valid2 = 1'b1; req_we2 = 1'b1; req_addr2 = 12'hABC; req_wdata2 = 20'hF1234;
      for (int c = 1; c <= 30 && lat2 == 0; c++) begin
         if (c == 2) req_valid2 = 1'b0;
         @(negedge clk);
         if (pin_oe2) begin
            if (nb2 < 5) got2[nb2*8 +: 8] = pin_out2;
            nb2++;
         end
         if (rsp_valid2) lat2 = c;
         @(posedge clk);
         #1;
      end
      check("narrow_beats", got2, 40'h0F_12_34_0A_BC);
      check("narrow_beat_count", nb2, 5);
      check("narrow_latency", lat2, 7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpu_pin_bridge.md
CPU_PIN_BRIDGE -- requirements
Module: cpu_pin_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, CPU address width in bits.
REQ-002 Parameter DATA_W, default 32, CPU data width in bits.
REQ-003 Parameter PIN_W, default 8, pin-bus width in bits; ABEATS=ceil(ADDR_W/PIN_W), DBEATS=ceil(DATA_W/PIN_W).
REQ-004 Parameter TIMEOUT, default 16, max idle cycles waiting for pin_ack per read beat (>=1).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  CPU request present.
REQ-008 req_ready  out  1  bridge accepts request this cycle.
REQ-009 req_we  in  1  1=write, 0=read.
REQ-010 req_addr  in  ADDR_W  request address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_W  read data, valid with rsp_valid on reads, 0 on writes.
REQ-014 rsp_err  out  1  read timed out, valid with rsp_valid.
REQ-015 pin_out  out  PIN_W  outbound beat (address or write data).
REQ-016 pin_in  in  PIN_W  inbound read-data beat.
REQ-017 pin_oe  out  1  1 while pin_out carries a driven beat.
REQ-018 pin_start  out  1  high on first address beat only.
REQ-019 pin_we  out  1  copy of latched req_we during a transaction.
REQ-020 pin_ack  in  1  external side presents valid pin_in this cycle.

Function
REQ-021 States: IDLE, ADDR, WDATA, TURN, RDATA, DONE.
REQ-022 req_ready=1 only in IDLE; handshake req_valid&req_ready latches addr, wdata, we, moves to ADDR.
REQ-023 ADDR: ABEATS cycles, beat k drives req_addr[k*PIN_W +: PIN_W], LS beat first, bits above ADDR_W zero-padded; pin_oe=1.
REQ-024 After last address beat: write -> WDATA, read -> TURN.
REQ-025 WDATA: DBEATS cycles, same slicing/padding of wdata, pin_oe=1, then DONE.
REQ-026 TURN: exactly one cycle, pin_oe=0, pin_out=0, then RDATA.
REQ-027 RDATA: pin_oe=0; each cycle with pin_ack=1 stores pin_in into beat k of rdata shift/assembly register, k increments; after DBEATS acks -> DONE.
REQ-028 RDATA wait counter reset on every ack; reaching TIMEOUT idle cycles -> DONE with rsp_err=1, unreceived beats read as 0.
REQ-029 DONE: one cycle, rsp_valid=1 with rsp_rdata/rsp_err, then IDLE; no new request accepted in DONE.
REQ-030 Padding bits of final read beat beyond DATA_W discarded.
REQ-031 pin_ack outside RDATA ignored; req_* changes outside IDLE ignored.
REQ-032 Latency: write = 1+ABEATS+DBEATS+1 cycles accept-to-rsp_valid; read = 1+ABEATS+1+ack-gated DBEATS+1.
REQ-033 Back-to-back: req_valid held high gets accepted the cycle after DONE.

Reset
REQ-034 rst=1 at a clock edge forces IDLE from any state, aborting transaction without rsp_valid.
REQ-035 Reset values: req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, pin_out=0, pin_oe=0, pin_start=0, pin_we=0, beat and wait counters 0.

Structure
REQ-036 Shared package cpu_bridge_pkg holds state enum and beat-count helper function (ceil divide).
REQ-037 One sub-module beat_counter (parametrised width, load/increment/terminal flag) used for beat and timeout counting.

Verification
REQ-038 Write addr 0x12345678, data 0xCAFEBABE, defaults -> pin_out 78,56,34,12,BE,BA,FE,CA, pin_start on first beat, rsp_valid cycle 10, rsp_rdata=0.
REQ-039 Read addr 0x00000010, pin_ack every cycle with pin_in EF,BE,AD,DE -> TURN one cycle, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-040 Read with pin_ack gaps of 3 cycles between beats -> same data, rsp_valid delayed 9 cycles, no error.
REQ-041 Read, no pin_ack after 2 beats (AA,BB) -> after 16 idle cycles rsp_err=1, rsp_rdata=0x0000BBAA.
REQ-042 rst asserted mid-WDATA -> next cycle IDLE, pin_oe=0, no rsp_valid; following request completes normally.
REQ-043 ADDR_W=12, DATA_W=20, PIN_W=8, write addr 0xABC data 0xF1234 -> beats BC,0A,34,12,0F.
